iiitb_ptvm_change_dispenser: RTL
================================

Name: iiitb_ptvm_change_dispenser

Overview:
Change/refund dispenser for the parking-ticket vending machine. It is the outbound counterpart of the coin-acceptor path: it takes a refund amount and emits coins to the hopper one at a time, using the same 2-bit coin encoding the machine accepts on its coin input. Selection is greedy (Rs10 first, then Rs5). Each coin uses a valid/ack handshake, a mandatory settle gap between coins, and an ack timeout with an error flag.

Parameters:
AMT_W, 4, width of the refund amount, in units of Rs5 (max refund 15 x Rs5 = Rs75).
GAP_CYCLES, 2, minimum cycles coin_valid stays low between consecutive coins (>=1).
ACK_TIMEOUT, 15, consecutive sampling edges with coin_valid high and no ack before abort (>=1).

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  synchronous reset, active-low (rst==0 at a rising edge resets).
req  in  1  start-refund strobe, sampled only in IDLE.
amt  in  AMT_W  refund amount in Rs5 units, captured with req.
busy  out  1  high from accept until done/abort.
coin_out  out  2  coin code: 2'b00 none, 2'b01 Rs5, 2'b10 Rs10 (2'b11 never driven).
coin_valid  out  1  coin_out is valid; held until ack or timeout.
coin_ack  in  1  hopper accepted coin; meaningful only while coin_valid==1.
done  out  1  one-cycle pulse after the final coin of a refund has been acked.
err  out  1  sticky timeout flag; cleared on the next accepted req or by reset.
remaining  out  AMT_W  undispensed amount, in Rs5 units.

Behaviour:
- Reset (rst==0 at an edge): busy=0, coin_out=2'b00, coin_valid=0, done=0, err=0, remaining=0, state=IDLE. Applies mid-refund; the in-flight coin is dropped and not counted.
- States: IDLE, ISSUE, GAP, FINISH.
- IDLE:
  - req=1 loads remaining=amt, sets busy=1, clears err.
  - If amt!=0, go to ISSUE, and coin_valid=1 in the cycle after the accepting edge (latency 1).
  - If amt==0, go to FINISH. No coin is issued.
- Coin select on entry to ISSUE: remaining>=2 gives 2'b10, otherwise 2'b01. coin_out is stable while coin_valid=1, and is 2'b00 whenever coin_valid=0.
- ISSUE, ack: coin_ack=1 at an edge (same-cycle ack allowed) clears coin_valid and subtracts 2 (Rs10) or 1 (Rs5) from remaining.
  - New remaining==0: done=1 and busy=0 in the next cycle, then go to IDLE. There is no gap after the last coin.
  - Otherwise go to GAP.
- ISSUE, no ack: after ACK_TIMEOUT consecutive edges without ack, set coin_valid=0, err=1, busy=0, go to IDLE. No done pulse. remaining holds the undispensed amount, including the unacked coin.
- GAP: coin_valid stays low for exactly GAP_CYCLES cycles, then returns to ISSUE with a fresh select.
- FINISH (amt==0 only): done=1 and busy=0 for one cycle, then IDLE.
- Ignored inputs:
  - req while busy is ignored; amt is not re-sampled.
  - coin_ack while coin_valid==0 is ignored.
- Timeout counter resets on each entry to ISSUE. Gap and timeout share one down-counter, sized clog2(max(GAP_CYCLES, ACK_TIMEOUT)+1).
- Arithmetic: remaining never underflows, because a Rs10 coin is selected only when remaining>=2. All arithmetic is unsigned at width AMT_W.
- Invariant: the sum of acked coin values plus remaining equals amt, at every cycle of a refund.

Decomposition:
- Shared package/include iiitb_ptvm_pkg, holding:
  - coin code constants COIN_NONE=2'b00, COIN_5=2'b01, COIN_10=2'b10, shared with the vending machine input decode;
  - the dispenser state encoding.
- One sub-module, iiitb_ptvm_cdown_timer: a loadable down-counter with a zero flag, used for both the gap and the timeout.

Test Plan:
- amt=3, req at edge 0, coin_ack tied 1:
  - coin 2'b10 valid in cycle 1;
  - valid low in cycles 2-3;
  - coin 2'b01 valid in cycle 4;
  - done=1 in cycle 5 only, busy low from cycle 5;
  - remaining 3 -> 1 -> 0.
- amt=4, ack delayed 3 cycles per coin: two 2'b10 coins, each held stable until ack, one done pulse, err=0.
- amt=0 with req: done pulses in the cycle after the accepting edge; coin_valid is never asserted.
- amt=5, no ack after the first coin: err=1 and coin_valid=0 after the 15th edge, remaining=5, no done. A new req with amt=1 clears err and dispenses 2'b01.
- rst=0 asserted mid-refund (during ISSUE, and separately during GAP): all outputs zero the next cycle. A req re-issued with a new amt afterwards then completes normally.
- req pulses while busy, plus coin_ack pulses during GAP: no effect on the coin sequence, remaining, or done timing.

Source files
------------

// File: rtl/iiitb_ptvm_pkg.sv
// rtl/iiitb_ptvm_pkg.sv - shared coin codes and change-dispenser state encoding
package iiitb_ptvm_pkg;

    // Same encoding the machine decodes on its coin input
    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_GAP    = 2'd2,
        ST_FINISH = 2'd3
    } disp_state_t;

    // Value of a coin code in Rs5 units
    function automatic logic [1:0] coin_units(input logic [1:0] code);
        return (code == COIN_10) ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/iiitb_ptvm_cdown_timer.sv
// rtl/iiitb_ptvm_cdown_timer.sv - loadable saturating down-counter with zero flag
module iiitb_ptvm_cdown_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/iiitb_ptvm_change_dispenser.sv
// rtl/iiitb_ptvm_change_dispenser.sv - greedy Rs10/Rs5 refund dispenser with ack handshake
module iiitb_ptvm_change_dispenser
    import iiitb_ptvm_pkg::*;
#(
    parameter int AMT_W       = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [AMT_W-1:0] amt,
    output logic             busy,
    output logic [1:0]       coin_out,
    output logic             coin_valid,
    input  logic             coin_ack,
    output logic             done,
    output logic             err,
    output logic [AMT_W-1:0] remaining
);

    localparam int CNT_MAX = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    // Timer is checked before decrementing, so N-1 gives exactly N edges
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(ACK_TIMEOUT - 1);

    disp_state_t      state, state_n;
    logic [1:0]       coin_out_n;
    logic             coin_valid_n, busy_n, done_n, err_n;
    logic [AMT_W-1:0] remaining_n;
    logic             tmr_load, tmr_dec, tmr_zero;
    logic [CNT_W-1:0] tmr_val;

    function automatic logic [1:0] select_coin(input logic [AMT_W-1:0] rem);
        return (rem >= AMT_W'(2)) ? COIN_10 : COIN_5;
    endfunction

    iiitb_ptvm_cdown_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            coin_out   <= COIN_NONE;
            coin_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            remaining  <= '0;
        end else begin
            state      <= state_n;
            coin_out   <= coin_out_n;
            coin_valid <= coin_valid_n;
            busy       <= busy_n;
            done       <= done_n;
            err        <= err_n;
            remaining  <= remaining_n;
        end
    end

    always_comb begin
        state_n      = state;
        coin_out_n   = coin_out;
        coin_valid_n = coin_valid;
        busy_n       = busy;
        done_n       = 1'b0;
        err_n        = err;
        remaining_n  = remaining;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        tmr_dec      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (req) begin
                    remaining_n = amt;
                    err_n       = 1'b0;
                    if (amt != '0) begin
                        state_n      = ST_ISSUE;
                        busy_n       = 1'b1;
                        coin_valid_n = 1'b1;
                        coin_out_n   = select_coin(amt);
                        tmr_load     = 1'b1;
                        tmr_val      = TO_LOAD;
                    end else begin
                        state_n = ST_FINISH;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                    end
                end
            end
            ST_ISSUE: begin
                if (coin_ack) begin
                    coin_valid_n = 1'b0;
                    coin_out_n   = COIN_NONE;
                    remaining_n  = remaining - AMT_W'(coin_units(coin_out));
                    if (remaining_n == '0) begin
                        // Last coin: no settle gap before reporting completion
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        state_n  = ST_GAP;
                        tmr_load = 1'b1;
                        tmr_val  = GAP_LOAD;
                    end
                end else if (tmr_zero) begin
                    // Abort keeps the unacked coin in remaining
                    state_n      = ST_IDLE;
                    coin_valid_n = 1'b0;
                    coin_out_n   = COIN_NONE;
                    err_n        = 1'b1;
                    busy_n       = 1'b0;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_GAP: begin
                if (tmr_zero) begin
                    state_n      = ST_ISSUE;
                    coin_valid_n = 1'b1;
                    coin_out_n   = select_coin(remaining);
                    tmr_load     = 1'b1;
                    tmr_val      = TO_LOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_FINISH: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule
